// File: rtl/sdram_responder.sv
// SDR SDRAM device-side responder: decodes the command bus, tracks mode and per-bank
// open rows, stores write data and returns read data at the programmed CAS latency.
// Protocol violations are latched into sticky ERR flags.
module sdram_responder #(
    parameter int unsigned ROW_KEEP = 4,
    parameter int unsigned TRCD     = 2,
    parameter int unsigned TRFC     = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CKE,
    input  logic        nCS,
    input  logic        nRAS,
    input  logic        nCAS,
    input  logic        nWE,
    input  logic [1:0]  BA,
    input  logic [11:0] ADDR,
    input  logic [1:0]  DQM,
    input  logic [15:0] DQ_IN,
    output logic [15:0] DQ_OUT,
    output logic        DQ_OE,
    output logic        MODE_SET,
    output logic [1:0]  CL,
    output logic        BL2,
    output logic [5:0]  ERR
);

    localparam int unsigned AW    = 2 + ROW_KEEP + 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned RCDW  = $clog2(TRCD + 1);
    localparam int unsigned RFCW  = $clog2(TRFC + 1);

    typedef enum logic [2:0] {
        CmdMrs   = 3'b000,
        CmdRef   = 3'b001,
        CmdPre   = 3'b010,
        CmdAct   = 3'b011,
        CmdWrite = 3'b100,
        CmdRead  = 3'b101,
        CmdBst   = 3'b110,
        CmdNop   = 3'b111
    } cmd_e;

    logic [15:0]         mem [DEPTH];
    logic [3:0]          bank_act_q, bank_act_d;
    logic [ROW_KEEP-1:0] row_q [4];
    logic [RCDW-1:0]     rcd_q [4];
    logic [RFCW-1:0]     rfc_q;
    logic                mode_set_q, bl2_q;
    logic [1:0]          cl_q;
    logic [5:0]          err_q, err_d;
    logic                wr_pend_q, wr_ap_q;
    logic [1:0]          wr_bank_q;
    logic [AW-1:0]       wr_idx_q;
    logic                rd_act_q, rd_bl2_q, rd_ap_q;
    logic [1:0]          rd_cl_q, rd_bank_q, dqm_q;
    logic [2:0]          rd_cnt_q;
    logic [AW-1:0]       rd_idx_q, rd_addr, acc_idx;
    logic [15:0]         dq_out_q;
    logic                dq_oe_q;

    cmd_e cmd;
    logic cmd_vld, cmd_real, is_mrs, is_ref, is_pre, is_act, is_wr, is_rd;
    logic bank_open, wr_ok, rd_ok, beat0, beat1, rd_last, rd_abort, mrs_bad;
    logic unused_addr;

    assign unused_addr = ^{ADDR[11], ADDR[9:8]};

    // Command decode and read-pipeline beat selection
    always_comb begin
        cmd       = cmd_e'({nRAS, nCAS, nWE});
        cmd_vld   = CKE & ~nCS;
        cmd_real  = cmd_vld & (cmd != CmdNop);
        is_mrs    = cmd_vld & (cmd == CmdMrs);
        is_ref    = cmd_vld & (cmd == CmdRef);
        is_pre    = cmd_vld & (cmd == CmdPre);
        is_act    = cmd_vld & (cmd == CmdAct);
        is_wr     = cmd_vld & (cmd == CmdWrite);
        is_rd     = cmd_vld & (cmd == CmdRead);
        bank_open = bank_act_q[BA];
        wr_ok     = is_wr & bank_open;
        rd_ok     = is_rd & bank_open;
        acc_idx   = {BA, row_q[BA], ADDR[7:0]};
        mrs_bad   = (ADDR[5:4] != 2'd2 && ADDR[5:4] != 2'd3) || (ADDR[2:1] != 2'b00);
        beat0     = rd_act_q && (rd_cnt_q == {1'b0, rd_cl_q} - 3'd1);
        beat1     = rd_act_q && rd_bl2_q && (rd_cnt_q == {1'b0, rd_cl_q});
        rd_last   = (beat0 && !rd_bl2_q) || beat1;
        // Any WRITE, or a READ that is actually performed, cuts the running burst short
        rd_abort  = rd_act_q && !rd_last && (is_wr || rd_ok);
        rd_addr   = beat1 ? (rd_idx_q ^ AW'(1)) : rd_idx_q;
    end

    // Bank open/close bookkeeping and sticky error accumulation
    always_comb begin
        bank_act_d = bank_act_q;
        if (rd_act_q && rd_ap_q && (rd_last || rd_abort)) bank_act_d[rd_bank_q] = 1'b0;
        if (wr_pend_q && wr_ap_q) bank_act_d[wr_bank_q] = 1'b0;
        if (wr_ok && !bl2_q && ADDR[10]) bank_act_d[BA] = 1'b0;
        if (is_pre) begin
            if (ADDR[10]) bank_act_d = 4'b0000;
            else          bank_act_d[BA] = 1'b0;
        end
        if (is_act && !bank_open) bank_act_d[BA] = 1'b1;

        err_d    = err_q;
        err_d[0] = err_q[0] | (is_mrs & mrs_bad);
        err_d[1] = err_q[1] | (is_act & bank_open);
        err_d[2] = err_q[2] | ((is_rd | is_wr) & ~bank_open);
        err_d[3] = err_q[3] | ((wr_ok | rd_ok) & (rcd_q[BA] != '0));
        err_d[4] = err_q[4] | (is_ref & (|bank_act_q)) | (cmd_real & (rfc_q != '0));
        err_d[5] = err_q[5] | (cmd_real & ~mode_set_q & ~(is_mrs | is_pre | is_ref));
    end

    // Control state: mode register, banks, timers, write and read bursts, data outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_act_q <= 4'b0000;
            rfc_q      <= '0;
            mode_set_q <= 1'b0;
            cl_q       <= 2'd2;
            bl2_q      <= 1'b0;
            err_q      <= '0;
            wr_pend_q  <= 1'b0;
            wr_ap_q    <= 1'b0;
            wr_bank_q  <= '0;
            wr_idx_q   <= '0;
            rd_act_q   <= 1'b0;
            rd_bl2_q   <= 1'b0;
            rd_ap_q    <= 1'b0;
            rd_cl_q    <= 2'd2;
            rd_bank_q  <= '0;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            dqm_q      <= '0;
            dq_out_q   <= '0;
            dq_oe_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= '0;
                rcd_q[i] <= '0;
            end
        end else if (CKE) begin
            bank_act_q <= bank_act_d;
            err_q      <= err_d;
            dqm_q      <= DQM;

            if (is_mrs) begin
                mode_set_q <= 1'b1;
                bl2_q      <= (ADDR[2:0] == 3'b001);
                if (ADDR[5:4] == 2'd2 || ADDR[5:4] == 2'd3) cl_q <= ADDR[5:4];
            end

            for (int i = 0; i < 4; i++) begin
                if (is_act && !bank_open && BA == 2'(i)) begin
                    row_q[i] <= ADDR[ROW_KEEP-1:0];
                    rcd_q[i] <= RCDW'(TRCD - 1);
                end else if (rcd_q[i] != '0) begin
                    rcd_q[i] <= rcd_q[i] - RCDW'(1);
                end
            end

            if (is_ref)              rfc_q <= RFCW'(TRFC);
            else if (rfc_q != '0)    rfc_q <= rfc_q - RFCW'(1);

            wr_pend_q <= 1'b0;
            if (wr_ok && bl2_q) begin
                wr_pend_q <= 1'b1;
                wr_idx_q  <= acc_idx ^ AW'(1);
                wr_ap_q   <= ADDR[10];
                wr_bank_q <= BA;
            end

            if (rd_act_q) rd_cnt_q <= rd_cnt_q + 3'd1;
            if (rd_last || is_wr) rd_act_q <= 1'b0;
            if (rd_ok) begin
                rd_act_q  <= 1'b1;
                rd_cnt_q  <= 3'd1;
                rd_cl_q   <= cl_q;
                rd_bl2_q  <= bl2_q;
                rd_idx_q  <= acc_idx;
                rd_ap_q   <= ADDR[10];
                rd_bank_q <= BA;
            end

            // DQM sampled one edge earlier gives the two-cycle read mask latency
            if (is_wr) begin
                dq_oe_q <= 1'b0;
            end else if (beat0 || beat1) begin
                dq_oe_q  <= ~(|dqm_q);
                dq_out_q <= mem[rd_addr];
            end else begin
                dq_oe_q <= 1'b0;
            end
        end
    end

    // Byte-masked array writes: beat 1 of a pending burst, then the current WRITE
    always_ff @(posedge CLK) begin
        if (CKE && !RST) begin
            if (wr_pend_q) begin
                if (!DQM[0]) mem[wr_idx_q][7:0]  <= DQ_IN[7:0];
                if (!DQM[1]) mem[wr_idx_q][15:8] <= DQ_IN[15:8];
            end
            if (wr_ok) begin
                if (!DQM[0]) mem[acc_idx][7:0]  <= DQ_IN[7:0];
                if (!DQM[1]) mem[acc_idx][15:8] <= DQ_IN[15:8];
            end
        end
    end

    // A WRITE on the bus turns the read driver off in the same cycle
    assign DQ_OE    = dq_oe_q & ~is_wr;
    assign DQ_OUT   = dq_out_q;
    assign MODE_SET = mode_set_q;
    assign CL       = cl_q;
    assign BL2      = bl2_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder.
module tb_sdram_responder;

    localparam logic [2:0] CmdMrs = 3'b000, CmdRef = 3'b001, CmdPre = 3'b010, CmdAct = 3'b011;
    localparam logic [2:0] CmdWr = 3'b100, CmdRd = 3'b101, CmdNop = 3'b111;

    logic        CLK = 1'b0, RST = 1'b1, CKE = 1'b1;
    logic        nCS = 1'b1, nRAS = 1'b1, nCAS = 1'b1, nWE = 1'b1;
    logic [1:0]  BA = '0, DQM = '0, CL;
    logic [11:0] ADDR = '0;
    logic [15:0] DQ_IN = '0, DQ_OUT;
    logic        DQ_OE, MODE_SET, BL2;
    logic [5:0]  ERR;

    int checks = 0;
    int errors = 0;
    logic oe_seen;

    sdram_responder dut (
        .CLK(CLK), .RST(RST), .CKE(CKE), .nCS(nCS), .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE),
        .BA(BA), .ADDR(ADDR), .DQM(DQM), .DQ_IN(DQ_IN), .DQ_OUT(DQ_OUT), .DQ_OE(DQ_OE),
        .MODE_SET(MODE_SET), .CL(CL), .BL2(BL2), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drive one command for one cycle; returns at the next negedge with a NOP on the bus
    task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [11:0] a,
                         input logic [15:0] d, input logic [1:0] m);
        nCS = 1'b0; {nRAS, nCAS, nWE} = c; BA = ba; ADDR = a; DQ_IN = d; DQM = m;
        @(negedge CLK);
        {nRAS, nCAS, nWE} = CmdNop; DQM = 2'b00; ADDR = '0;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        nops(2);
        RST = 1'b0;
        nops(1);
        checks++; if (MODE_SET !== 1'b0) begin errors++; $display("FAIL reset_mode_set: got %b want 0", MODE_SET); end
        checks++; if (CL !== 2'd2) begin errors++; $display("FAIL reset_cl: got %0d want 2", CL); end
        checks++; if (BL2 !== 1'b0) begin errors++; $display("FAIL reset_bl2: got %b want 0", BL2); end
        checks++; if (ERR !== 6'b0) begin errors++; $display("FAIL reset_err: got %b want 000000", ERR); end
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", DQ_OE); end
        checks++; if (DQ_OUT !== 16'h0) begin errors++; $display("FAIL reset_dq_out: got %h want 0000", DQ_OUT); end
    endtask

    task automatic test_init;
        issue(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            issue(CmdRef, 2'd0, 12'h000, 16'h0, 2'b00);
            nops(7);
        end
        issue(CmdMrs, 2'd0, 12'h020, 16'h0, 2'b00);
        checks++; if (MODE_SET !== 1'b1) begin errors++; $display("FAIL init_mode_set: got %b want 1", MODE_SET); end
        checks++; if (CL !== 2'd2) begin errors++; $display("FAIL init_cl: got %0d want 2", CL); end
        checks++; if (BL2 !== 1'b0) begin errors++; $display("FAIL init_bl2: got %b want 0", BL2); end
        checks++; if (ERR !== 6'b0) begin errors++; $display("FAIL init_err: got %b want 000000", ERR); end
    endtask

    task automatic test_single_rw;
        issue(CmdAct, 2'd1, 12'h005, 16'h0, 2'b00);
        nops(2);
        issue(CmdWr, 2'd1, 12'h410, 16'hA5C3, 2'b00);
        issue(CmdAct, 2'd1, 12'h005, 16'h0, 2'b00);
        nops(2);
        issue(CmdRd, 2'd1, 12'h410, 16'h0, 2'b00);
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL single_oe_cl1: got %b want 0", DQ_OE); end
        nops(1);
        checks++; if (DQ_OE !== 1'b1) begin errors++; $display("FAIL single_oe_cl2: got %b want 1", DQ_OE); end
        checks++; if (DQ_OUT !== 16'hA5C3) begin errors++; $display("FAIL single_data: got %h want a5c3", DQ_OUT); end
        nops(1);
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL single_oe_after: got %b want 0", DQ_OE); end
        // Auto-precharge closed bank 1, so a fresh ACT must not flag a double activate
        issue(CmdAct, 2'd1, 12'h005, 16'h0, 2'b00);
        checks++; if (ERR !== 6'b0) begin errors++; $display("FAIL single_bank_idle: got %b want 000000", ERR); end
        issue(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    endtask

    task automatic test_bl2_cl3_mask;
        issue(CmdAct, 2'd0, 12'h003, 16'h0, 2'b00);
        nops(2);
        issue(CmdWr, 2'd0, 12'h020, 16'h5A7E, 2'b00);
        issue(CmdMrs, 2'd0, 12'h031, 16'h0, 2'b00);
        checks++; if (CL !== 2'd3) begin errors++; $display("FAIL bl2_cl: got %0d want 3", CL); end
        checks++; if (BL2 !== 1'b1) begin errors++; $display("FAIL bl2_flag: got %b want 1", BL2); end
        issue(CmdWr, 2'd0, 12'h021, 16'h1111, 2'b00);
        issue(CmdNop, 2'd0, 12'h000, 16'h2222, 2'b01);
        issue(CmdRd, 2'd0, 12'h021, 16'h0, 2'b00);
        nops(1);
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL bl2_oe_early: got %b want 0", DQ_OE); end
        nops(1);
        checks++; if (DQ_OE !== 1'b1 || DQ_OUT !== 16'h1111) begin errors++; $display("FAIL bl2_beat0: got oe=%b %h want oe=1 1111", DQ_OE, DQ_OUT); end
        nops(1);
        checks++; if (DQ_OE !== 1'b1 || DQ_OUT !== 16'h227E) begin errors++; $display("FAIL bl2_beat1: got oe=%b %h want oe=1 227e", DQ_OE, DQ_OUT); end
        nops(1);
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL bl2_oe_end: got %b want 0", DQ_OE); end
        checks++; if (ERR !== 6'b0) begin errors++; $display("FAIL bl2_err: got %b want 000000", ERR); end
        issue(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    endtask

    task automatic test_read_dqm;
        issue(CmdMrs, 2'd0, 12'h020, 16'h0, 2'b00);
        issue(CmdAct, 2'd2, 12'h001, 16'h0, 2'b00);
        nops(2);
        issue(CmdWr, 2'd2, 12'h000, 16'hC0DE, 2'b00);
        issue(CmdRd, 2'd2, 12'h000, 16'h0, 2'b11);
        oe_seen = DQ_OE;
        nops(1);
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL dqm_beat_masked: got %b want 0", DQ_OE); end
        oe_seen |= DQ_OE;
        nops(1);
        oe_seen |= DQ_OE;
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL dqm_oe_window: got %b want 0", oe_seen); end
        issue(CmdPre, 2'd2, 12'h000, 16'h0, 2'b00);
    endtask

    task automatic test_interrupt;
        issue(CmdAct, 2'd3, 12'h000, 16'h0, 2'b00);
        nops(2);
        issue(CmdRd, 2'd3, 12'h005, 16'h0, 2'b00);
        oe_seen = DQ_OE;
        issue(CmdWr, 2'd3, 12'h005, 16'h1234, 2'b00);
        oe_seen |= DQ_OE;
        for (int i = 0; i < 3; i++) begin
            nops(1);
            oe_seen |= DQ_OE;
        end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL interrupt_oe: got %b want 0", oe_seen); end
        checks++; if (ERR !== 6'b0) begin errors++; $display("FAIL interrupt_err: got %b want 000000", ERR); end
        issue(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    endtask

    task automatic test_violations;
        issue(CmdRd, 2'd1, 12'h000, 16'h0, 2'b00);
        checks++; if (ERR !== 6'b000100) begin errors++; $display("FAIL viol_idle_read: got %b want 000100", ERR); end
        oe_seen = DQ_OE;
        for (int i = 0; i < 3; i++) begin
            nops(1);
            oe_seen |= DQ_OE;
        end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL viol_idle_oe: got %b want 0", oe_seen); end
        issue(CmdAct, 2'd0, 12'h000, 16'h0, 2'b00);
        issue(CmdAct, 2'd0, 12'h000, 16'h0, 2'b00);
        checks++; if (ERR !== 6'b000110) begin errors++; $display("FAIL viol_double_act: got %b want 000110", ERR); end
        issue(CmdAct, 2'd2, 12'h001, 16'h0, 2'b00);
        issue(CmdRd, 2'd2, 12'h000, 16'h0, 2'b00);
        checks++; if (ERR !== 6'b001110) begin errors++; $display("FAIL viol_trcd: got %b want 001110", ERR); end
        nops(1);
        checks++; if (DQ_OE !== 1'b1 || DQ_OUT !== 16'hC0DE) begin errors++; $display("FAIL viol_trcd_data: got oe=%b %h want oe=1 c0de", DQ_OE, DQ_OUT); end
        nops(1);
        issue(CmdRef, 2'd0, 12'h000, 16'h0, 2'b00);
        checks++; if (ERR !== 6'b011110) begin errors++; $display("FAIL viol_ref_open: got %b want 011110", ERR); end
        nops(5);
        issue(CmdPre, 2'd0, 12'h400, 16'h0, 2'b00);
    endtask

    task automatic test_reset_mid_burst;
        issue(CmdMrs, 2'd0, 12'h031, 16'h0, 2'b00);
        issue(CmdAct, 2'd1, 12'h002, 16'h0, 2'b00);
        nops(2);
        issue(CmdRd, 2'd1, 12'h000, 16'h0, 2'b00);
        nops(2);
        checks++; if (DQ_OE !== 1'b1) begin errors++; $display("FAIL rst_burst_live: got %b want 1", DQ_OE); end
        #2 RST = 1'b1;
        #1;
        checks++; if (DQ_OE !== 1'b0) begin errors++; $display("FAIL rst_async_oe: got %b want 0", DQ_OE); end
        checks++; if (ERR !== 6'b0) begin errors++; $display("FAIL rst_async_err: got %b want 000000", ERR); end
        checks++; if (MODE_SET !== 1'b0) begin errors++; $display("FAIL rst_async_mode: got %b want 0", MODE_SET); end
        checks++; if (CL !== 2'd2 || BL2 !== 1'b0) begin errors++; $display("FAIL rst_async_cl: got cl=%0d bl2=%b want cl=2 bl2=0", CL, BL2); end
        @(negedge CLK);
        RST = 1'b0;
        oe_seen = DQ_OE;
        for (int i = 0; i < 3; i++) begin
            nops(1);
            oe_seen |= DQ_OE;
        end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rst_burst_aborted: got %b want 0", oe_seen); end
        // ACT before any MRS is only a mode-not-set violation
        issue(CmdAct, 2'd0, 12'h000, 16'h0, 2'b00);
        checks++; if (ERR !== 6'b100000) begin errors++; $display("FAIL pre_mode_act: got %b want 100000", ERR); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset;
        test_init;
        test_single_rw;
        test_bl2_cl3_mask;
        test_read_dqm;
        test_interrupt;
        test_violations;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
